// File: rtl/ioctl_region_loader.sv
// Routes the HPS ioctl download stream to NUM_REGIONS address-decoded write ports
// through a one-byte buffer, captures the DIP bank and reports ROM load status.
module ioctl_region_loader #(
    parameter int                          NUM_REGIONS = 4,
    parameter int                          ADDR_W      = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h0C000, 25'h08000, 25'h04000, 25'h0},
    parameter logic [ADDR_W-1:0]           END_ADDR    = 25'h10000,
    parameter logic [7:0]                  ROM_INDEX   = 8'd0,
    parameter logic [7:0]                  DIP_INDEX   = 8'd254,
    parameter int                          DIP_BYTES   = 8,
    parameter logic [DIP_BYTES*8-1:0]      DIP_DEFAULT = 64'h0
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_download,
    input  logic                     ioctl_wr,
    input  logic [ADDR_W-1:0]        ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    input  logic [7:0]               ioctl_index,
    output logic                     ioctl_wait,
    output logic [NUM_REGIONS-1:0]   rgn_wr,
    output logic [ADDR_W-1:0]        rgn_addr,
    output logic [7:0]               rgn_data,
    input  logic [NUM_REGIONS-1:0]   rgn_ready,
    output logic [DIP_BYTES*8-1:0]   dip_out,
    output logic                     dip_valid,
    output logic                     rom_loaded,
    output logic [ADDR_W-1:0]        byte_count,
    output logic                     err_overrun,
    output logic                     err_oob
);

    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOADING, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;

    logic              rom_strobe_p0;
    logic              rom_oob_p0;
    logic              rom_cap_p0;
    logic              dip_wr_p0;
    logic              rom_dl_p0;
    logic              dl_rise_p0;
    logic              dl_fall_p0;
    logic [SEL_W-1:0]  sel_p0;
    logic              rom_dl_q;

    logic              buf_vld_p1;
    logic [ADDR_W-1:0] buf_addr_p1;
    logic [7:0]        buf_data_p1;
    logic [SEL_W-1:0]  buf_sel_p1;
    logic              accept_p1;

    logic [DIP_BYTES*8-1:0] dip_q;
    logic                   dip_valid_q;

    // Unsigned a >= b via the borrow of a widened subtraction, so a zero base
    // does not turn into a constant comparison.
    function automatic logic addr_ge(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [ADDR_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return ~diff[ADDR_W];
    endfunction

    function automatic logic [SEL_W-1:0] region_of(input logic [ADDR_W-1:0] a);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (addr_ge(a, REGION_BASE[i*ADDR_W +: ADDR_W]))
                r = SEL_W'(i);
        end
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [SEL_W-1:0] s);
        return REGION_BASE[s*ADDR_W +: ADDR_W];
    endfunction

    // Stage p0: strobe qualification and region decode
    always_comb begin
        rom_dl_p0     = ioctl_download & (ioctl_index == ROM_INDEX);
        rom_strobe_p0 = ioctl_wr & rom_dl_p0;
        rom_oob_p0    = addr_ge(ioctl_addr, END_ADDR) |
                        ~addr_ge(ioctl_addr, REGION_BASE[ADDR_W-1:0]);
        sel_p0        = region_of(ioctl_addr);
        rom_cap_p0    = rom_strobe_p0 & ~rom_oob_p0 & ~buf_vld_p1;
        dip_wr_p0     = ioctl_wr & (ioctl_index == DIP_INDEX) &
                        ~addr_ge(ioctl_addr, ADDR_W'(DIP_BYTES));
        dl_rise_p0    = rom_dl_p0 & ~rom_dl_q;
        dl_fall_p0    = ~rom_dl_p0 & rom_dl_q;
    end

    // Stage p1: one-entry buffer presented to the selected region
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_vld_p1  <= 1'b0;
            buf_addr_p1 <= '0;
            buf_data_p1 <= '0;
            buf_sel_p1  <= '0;
        end else if (rom_cap_p0) begin
            buf_vld_p1  <= 1'b1;
            buf_addr_p1 <= ioctl_addr - base_of(sel_p0);
            buf_data_p1 <= ioctl_dout;
            buf_sel_p1  <= sel_p0;
        end else if (accept_p1) begin
            buf_vld_p1  <= 1'b0;
        end
    end

    always_comb begin
        rgn_wr = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (buf_vld_p1 && buf_sel_p1 == SEL_W'(i))
                rgn_wr[i] = 1'b1;
        end
    end

    assign accept_p1  = |(rgn_wr & rgn_ready);
    assign ioctl_wait = buf_vld_p1;
    assign rgn_addr   = buf_addr_p1;
    assign rgn_data   = buf_data_p1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_dl_q    <= 1'b0;
            byte_count  <= '0;
            err_overrun <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            rom_dl_q <= rom_dl_p0;
            if (dl_rise_p0)
                byte_count <= '0;
            else if (accept_p1)
                byte_count <= byte_count + 1'b1;
            // A new download clears the sticky flags, but a fault in the same
            // cycle still gets recorded.
            err_overrun <= (err_overrun & ~dl_rise_p0) | (rom_strobe_p0 & buf_vld_p1);
            err_oob     <= (err_oob & ~dl_rise_p0) | (rom_strobe_p0 & rom_oob_p0);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (dl_rise_p0) state_d = S_LOADING;
            S_LOADING: if (dl_fall_p0) state_d = buf_vld_p1 ? S_DRAIN : S_DONE;
            S_DRAIN: begin
                if (dl_rise_p0)
                    state_d = S_LOADING;
                else if (!buf_vld_p1)
                    state_d = S_DONE;
            end
            S_DONE:    if (dl_rise_p0) state_d = S_LOADING;
            default:   state_d = S_IDLE;
        endcase
    end

    assign rom_loaded = (state_q == S_DONE);

    // DIP bank is written directly; it never waits on the ROM buffer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dip_q       <= DIP_DEFAULT;
            dip_valid_q <= 1'b0;
        end else if (dip_wr_p0) begin
            for (int n = 0; n < DIP_BYTES; n++) begin
                if (ioctl_addr == ADDR_W'(n))
                    dip_q[8*n +: 8] <= ioctl_dout;
            end
            dip_valid_q <= 1'b1;
        end
    end

    assign dip_out   = dip_q;
    assign dip_valid = dip_valid_q;

endmodule

// File: tb/tb_ioctl_region_loader.sv
// Directed bench for ioctl_region_loader: region decode table, full stream,
// stall, overrun, out-of-range, DIP capture and reset-mid-download.
module tb_ioctl_region_loader;

    localparam int          AW  = 25;
    localparam logic [63:0] DEF = 64'h0123_4567_89AB_CDEF;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic          ioctl_wait;
    logic [3:0]    rgn_wr;
    logic [AW-1:0] rgn_addr;
    logic [7:0]    rgn_data;
    logic [3:0]    rgn_ready;
    logic [63:0]   dip_out;
    logic          dip_valid;
    logic          rom_loaded;
    logic [AW-1:0] byte_count;
    logic          err_overrun;
    logic          err_oob;

    ioctl_region_loader #(.DIP_DEFAULT(DEF)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .rgn_wr(rgn_wr), .rgn_addr(rgn_addr),
        .rgn_data(rgn_data), .rgn_ready(rgn_ready), .dip_out(dip_out),
        .dip_valid(dip_valid), .rom_loaded(rom_loaded), .byte_count(byte_count),
        .err_overrun(err_overrun), .err_oob(err_oob)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [3:0]    exp_wr;
        logic [AW-1:0] exp_off;
    } vec_t;

    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wr0, bad, wait_hi, stall_ok, dip_wait;

        vt[0] = '{25'h00000, 8'h10, 4'b0001, 25'h0000};
        vt[1] = '{25'h03FFF, 8'h21, 4'b0001, 25'h3FFF};
        vt[2] = '{25'h04000, 8'h32, 4'b0010, 25'h0000};
        vt[3] = '{25'h07FFF, 8'h43, 4'b0010, 25'h3FFF};
        vt[4] = '{25'h08000, 8'h54, 4'b0100, 25'h0000};
        vt[5] = '{25'h0BFFF, 8'h65, 4'b0100, 25'h3FFF};
        vt[6] = '{25'h0C000, 8'h76, 4'b1000, 25'h0000};
        vt[7] = '{25'h0FFFF, 8'h87, 4'b1000, 25'h3FFF};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = 8'd0; rgn_ready = 4'b1111;
        repeat (3) next_cyc();
        reset = 1'b0;
        @(negedge clk_sys);
        chk("reset_rgn_wr", 64'(rgn_wr), 64'h0);
        chk("reset_wait", 64'(ioctl_wait), 64'h0);
        chk("reset_rgn_addr_data", 64'({rgn_addr, rgn_data}), 64'h0);
        chk("reset_dip_out", dip_out, DEF);
        chk("reset_flags", 64'({dip_valid, rom_loaded, err_overrun, err_oob}), 64'h0);
        chk("reset_byte_count", 64'(byte_count), 64'h0);
        next_cyc();

        // Full 16 KiB stream into region 0 with zero wait states
        ioctl_download = 1'b1;
        next_cyc();
        wr0 = 0; bad = 0; wait_hi = 0;
        for (int i = 0; i < 16384; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = AW'(i); ioctl_dout = i[7:0] ^ 8'hA5;
            @(negedge clk_sys);
            if (ioctl_wait) wait_hi++;
            next_cyc();
            ioctl_wr = 1'b0;
            @(negedge clk_sys);
            if (ioctl_wait) wait_hi++;
            if (rgn_wr == 4'b0001) begin
                wr0++;
                if (rgn_addr !== AW'(i) || rgn_data !== (i[7:0] ^ 8'hA5)) bad++;
            end else begin
                bad++;
            end
            next_cyc();
        end
        chk("stream_writes", 64'(wr0), 64'd16384);
        chk("stream_bad_beats", 64'(bad), 64'd0);
        chk("stream_wait_cycles", 64'(wait_hi), 64'd16384);
        chk("stream_byte_count", 64'(byte_count), 64'h4000);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("stream_loaded_before", 64'(rom_loaded), 64'h0);
        next_cyc();
        @(negedge clk_sys);
        chk("stream_loaded_after", 64'(rom_loaded), 64'h1);
        next_cyc();

        // Region decode table in a fresh download
        ioctl_download = 1'b1;
        next_cyc();
        @(negedge clk_sys);
        chk("rise_clears_loaded", 64'(rom_loaded), 64'h0);
        chk("rise_clears_count", 64'(byte_count), 64'h0);
        next_cyc();
        for (int v = 0; v < 8; v++) begin
            ioctl_wr = 1'b1; ioctl_addr = vt[v].addr; ioctl_dout = vt[v].data;
            next_cyc();
            ioctl_wr = 1'b0;
            @(negedge clk_sys);
            chk($sformatf("vec%0d_rgn_wr", v), 64'(rgn_wr), 64'(vt[v].exp_wr));
            chk($sformatf("vec%0d_rgn_addr", v), 64'(rgn_addr), 64'(vt[v].exp_off));
            chk($sformatf("vec%0d_rgn_data", v), 64'(rgn_data), 64'(vt[v].data));
            next_cyc();
        end
        chk("table_byte_count", 64'(byte_count), 64'd8);

        // Stall: region 2 not ready for five cycles
        rgn_ready = 4'b1011;
        ioctl_wr = 1'b1; ioctl_addr = 25'h08005; ioctl_dout = 8'h3C;
        next_cyc();
        ioctl_wr = 1'b0;
        stall_ok = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_sys);
            if (rgn_wr == 4'b0100 && rgn_addr == 25'h5 && rgn_data == 8'h3C && ioctl_wait)
                stall_ok++;
            next_cyc();
        end
        chk("stall_stable_cycles", 64'(stall_ok), 64'd5);
        rgn_ready = 4'b1111;
        @(negedge clk_sys);
        chk("stall_accept_wr", 64'(rgn_wr), 64'b0100);
        chk("stall_accept_wait", 64'(ioctl_wait), 64'h1);
        next_cyc();
        @(negedge clk_sys);
        chk("stall_wait_release", 64'(ioctl_wait), 64'h0);
        chk("stall_wr_release", 64'(rgn_wr), 64'h0);
        chk("stall_byte_count", 64'(byte_count), 64'd9);
        next_cyc();

        // Overrun: second strobe while the buffer is held full
        rgn_ready = 4'b1011;
        ioctl_wr = 1'b1; ioctl_addr = 25'h08010; ioctl_dout = 8'h11;
        next_cyc();
        ioctl_addr = 25'h09000; ioctl_dout = 8'h22;
        next_cyc();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("ovr_flag", 64'(err_overrun), 64'h1);
        chk("ovr_held_addr", 64'(rgn_addr), 64'h10);
        chk("ovr_held_data", 64'(rgn_data), 64'h11);
        next_cyc();
        rgn_ready = 4'b1111;
        next_cyc();
        @(negedge clk_sys);
        chk("ovr_no_second_write", 64'(rgn_wr), 64'h0);
        chk("ovr_byte_count", 64'(byte_count), 64'd10);
        next_cyc();
        ioctl_download = 1'b0;
        repeat (2) next_cyc();

        // Accept and strobe in the same cycle, then an out-of-range byte
        ioctl_download = 1'b1;
        next_cyc();
        @(negedge clk_sys);
        chk("rise_clears_overrun", 64'(err_overrun), 64'h0);
        next_cyc();
        ioctl_wr = 1'b1; ioctl_addr = 25'h00100; ioctl_dout = 8'h77;
        next_cyc();
        ioctl_addr = 25'h00200; ioctl_dout = 8'h88;
        next_cyc();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("b2b_dropped", 64'(rgn_wr), 64'h0);
        chk("b2b_overrun", 64'(err_overrun), 64'h1);
        chk("b2b_byte_count", 64'(byte_count), 64'd1);
        next_cyc();
        ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h99;
        next_cyc();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("oob_no_wr", 64'(rgn_wr), 64'h0);
        chk("oob_no_wait", 64'(ioctl_wait), 64'h0);
        chk("oob_flag", 64'(err_oob), 64'h1);
        chk("oob_byte_count", 64'(byte_count), 64'd1);
        next_cyc();
        ioctl_download = 1'b0;
        next_cyc();
        @(negedge clk_sys);
        chk("oob_dl_loaded", 64'(rom_loaded), 64'h1);
        next_cyc();

        // DIP download
        ioctl_index = 8'd254; ioctl_download = 1'b1;
        dip_wait = 0;
        next_cyc();
        ioctl_wr = 1'b1; ioctl_addr = 25'd1; ioctl_dout = 8'h5A;
        @(negedge clk_sys);
        if (ioctl_wait) dip_wait++;
        next_cyc();
        ioctl_addr = 25'd9; ioctl_dout = 8'hFF;
        @(negedge clk_sys);
        if (ioctl_wait) dip_wait++;
        next_cyc();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        if (ioctl_wait) dip_wait++;
        chk("dip_out", dip_out, 64'h0123_4567_89AB_5AEF);
        chk("dip_valid", 64'(dip_valid), 64'h1);
        chk("dip_no_wait", 64'(dip_wait), 64'd0);
        chk("dip_no_rgn_wr", 64'(rgn_wr), 64'h0);
        next_cyc();
        ioctl_download = 1'b0;
        repeat (2) next_cyc();
        @(negedge clk_sys);
        chk("dip_loaded_unchanged", 64'(rom_loaded), 64'h1);
        chk("dip_err_oob_kept", 64'(err_oob), 64'h1);
        next_cyc();

        // New ROM download clears flags; then reset with a byte pending
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        next_cyc();
        @(negedge clk_sys);
        chk("rise_clears_oob", 64'(err_oob), 64'h0);
        chk("rise2_clears_loaded", 64'(rom_loaded), 64'h0);
        next_cyc();
        rgn_ready = 4'b1110;
        ioctl_wr = 1'b1; ioctl_addr = 25'h00042; ioctl_dout = 8'hC3;
        next_cyc();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("pending_before_reset", 64'(rgn_wr), 64'b0001);
        next_cyc();
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        rgn_ready = 4'b1111;
        @(negedge clk_sys);
        chk("reset_drops_wr", 64'(rgn_wr), 64'h0);
        chk("reset_drops_wait", 64'(ioctl_wait), 64'h0);
        chk("reset_drops_count", 64'(byte_count), 64'h0);
        chk("reset_dip_restored", dip_out, DEF);
        next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ioctl_region_loader.md
Name: ioctl_region_loader

Overview:
- Parametrised successor to the single-target ROM download path (index 0 to the core) and the 8-byte DIP capture (index 254) in the arcade top level.
- Splits the HPS ioctl download stream into NUM_REGIONS independent downstream write ports, selected by address range.
- Applies per-region backpressure through ioctl_wait using a one-entry buffer.
- Captures a configurable DIP bank and reports load status (loaded, byte count, error flags) to the core.

Parameters:
NUM_REGIONS, 4, number of downstream write ports (1..8)
ADDR_W, 25, ioctl address width
REGION_BASE, {25'h0C000,25'h08000,25'h04000,25'h0}, packed NUM_REGIONS*ADDR_W start addresses, region 0 in LSBs, strictly ascending
END_ADDR, 25'h10000, first address past the last region
ROM_INDEX, 8'd0, ioctl_index routed to regions
DIP_INDEX, 8'd254, ioctl_index captured as DIP bytes
DIP_BYTES, 8, DIP bank size in bytes
DIP_DEFAULT, 64'h0, packed DIP_BYTES*8 reset value of dip_out

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
ioctl_download  in  1  download active
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  ADDR_W  byte address
ioctl_dout  in  8  byte data
ioctl_index  in  8  download index
ioctl_wait  out  1  stall request to HPS
rgn_wr  out  NUM_REGIONS  one-hot write request, held until accepted
rgn_addr  out  ADDR_W  address minus the selected region base
rgn_data  out  8  write data
rgn_ready  in  NUM_REGIONS  per-region accept; a transfer completes when rgn_wr[i]&rgn_ready[i]
dip_out  out  DIP_BYTES*8  captured DIP bank, byte n at [8n+7:8n]
dip_valid  out  1  at least one DIP byte written since reset
rom_loaded  out  1  ROM download finished and fully drained
byte_count  out  ADDR_W  ROM bytes accepted by regions in the current download
err_overrun  out  1  sticky: ROM strobe arrived while buffer full
err_oob  out  1  sticky: ROM byte at or above END_ADDR

Behaviour:
- Reset values:
  - rgn_wr=0, ioctl_wait=0, rgn_addr=0, rgn_data=0.
  - dip_out=DIP_DEFAULT, dip_valid=0, rom_loaded=0, byte_count=0, err_*=0.
  - State=IDLE, buffer empty.
- Reset mid-download drops the buffered byte and does not complete it.
- Buffer states and ioctl_wait:
  - Buffer holds one byte: addr offset, data, region select.
  - ioctl_wait = buffer full, registered. It asserts the cycle after capture and deasserts the cycle after the accepting handshake.
- Region select:
  - Region i owns [BASE[i], BASE[i+1]); the last region owns [BASE[N-1], END_ADDR).
  - Decode uses a priority compare, highest matching base wins.
- ROM capture:
  - Condition: ioctl_wr & ioctl_download & index==ROM_INDEX & buffer empty.
  - Action: load the buffer. rgn_wr[sel]=1 from the next cycle, with rgn_addr = addr - BASE[sel].
  - Zero-wait path: with rgn_ready high, latency is strobe-to-rgn_wr 1 cycle, accept at the end of that cycle, so one byte per 2 cycles is sustained.
- Handshake:
  - rgn_wr, rgn_addr and rgn_data stay stable while rgn_ready[sel]=0.
  - On accept, rgn_wr clears next cycle, the buffer empties, and byte_count increments (wraps at 2^ADDR_W).
- Accept and new strobe in the same cycle: the buffer is treated as full. The strobe is dropped and err_overrun is set, because HPS must honour ioctl_wait.
- Out-of-range address (addr >= END_ADDR or addr < BASE[0]): byte discarded, no rgn_wr, err_oob set, buffer unchanged, byte_count unchanged.
- DIP capture:
  - Condition: ioctl_wr & index==DIP_INDEX & addr < DIP_BYTES.
  - Writes dip_out byte addr in the same edge and sets dip_valid.
  - Never stalls and is independent of the buffer. Higher DIP addresses are ignored.
- Strobes with any other index are ignored.
- State machine (ROM index only):
  - IDLE → LOADING: rising edge of (ioctl_download & index==ROM_INDEX). Clears byte_count, err_overrun, err_oob and rom_loaded.
  - LOADING → DRAIN: on download falling edge.
  - DRAIN → DONE: when the buffer is empty, which may be the same cycle as the falling edge. rom_loaded=1 from the next cycle.
  - DONE → LOADING: on a new ROM download rising edge.
- Download edges with index==DIP_INDEX do not affect the state or rom_loaded.

Test Plan:
- Reset → rgn_wr=0, dip_out=DIP_DEFAULT, rom_loaded=0, all flags 0.
- ROM stream 0x0000–0x3FFF with rgn_ready all high → 16384 writes on rgn_wr[0], rgn_addr equal to the source address, byte_count=0x4000, ioctl_wait pulses for 1 cycle per byte, rom_loaded=1 one cycle after drain.
- Byte at 0x8005 with rgn_ready[2] held low for 5 cycles:
  - rgn_wr=4'b0100 and rgn_addr=0x0005 held stable for all 5 cycles.
  - ioctl_wait high throughout the stall.
  - Accept on the 6th cycle, then ioctl_wait=0 on the next cycle.
- Strobe at 0x9000 while the buffer is full → byte dropped, err_overrun=1, and the buffered byte is still delivered intact.
- Byte at 0x10000 → no rgn_wr, err_oob=1, byte_count unchanged. A following download rising edge clears err_oob.
- DIP index 254, addr 1 = 0x5A, addr 9 = 0xFF → dip_out[15:8]=0x5A, other bytes unchanged, dip_valid=1, ioctl_wait never asserted, rom_loaded unchanged.
